// File: rtl/blk_mem_pkg.sv
// Shared widths, word/address types and the read-path reset value for blk_mem_gen.
package blk_mem_pkg;
  localparam int unsigned DATA_WIDTH_DEF = 64;
  localparam int unsigned ADDR_WIDTH_DEF = 12;

  typedef logic [DATA_WIDTH_DEF-1:0] word_t;
  typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;

  localparam word_t RESET_DOUT = '0;
endpackage

// File: rtl/blk_mem_array.sv
// Raw simple dual-port storage: one write port, one read-first registered read port.
// No reset anywhere so synthesis can map it onto block RAM.
import blk_mem_pkg::*;

module blk_mem_array #(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Separate process and non-blocking update give read-first on same-address collisions.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end
endmodule

// File: rtl/blk_mem_gen.sv
// 4096x64 simple dual-port SRAM wrapper: read-path reset, optional second output
// register (`BLK_MEM_OUT_REG_EN`, 2-cycle read latency) and control X-checks.
import blk_mem_pkg::*;

module blk_mem_gen #(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  enb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb
);
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] stage1;
  logic                  rd_valid;
  logic                  wr;

  assign wr = ena && wea;

  blk_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clka),
    .we   (wr),
    .waddr(addra),
    .wdata(dina),
    .re   (enb),
    .raddr(addrb),
    .rdata(rd_data)
  );

  // The array register has no reset; a valid flag masks it to zero from a reset
  // edge until the next enabled read reloads it.
  always_ff @(posedge clka) begin
    if (rsta) begin
      rd_valid <= 1'b0;
    end else if (enb) begin
      rd_valid <= 1'b1;
    end
  end

  assign stage1 = rd_valid ? rd_data : DATA_WIDTH'(RESET_DOUT);

`ifdef BLK_MEM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] out_q;

  always_ff @(posedge clka) begin
    if (rsta) begin
      out_q <= DATA_WIDTH'(RESET_DOUT);
    end else if (enb) begin
      out_q <= stage1;
    end
  end

  assign doutb = out_q;
`else
  assign doutb = stage1;
`endif

  ctrl_known: assert property (@(posedge clka) !$isunknown({ena, wea}));
endmodule

// File: tb/tb_blk_mem_gen.sv
// Directed bench for blk_mem_gen; expected values are hand-derived constants.
module tb_blk_mem_gen;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 12;
`ifdef BLK_MEM_OUT_REG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  localparam logic [DW-1:0] V_A   = 64'hABCDABCDABCDABCD;
  localparam logic [DW-1:0] V_B   = 64'hBCDABCDABCDABCDA;
  localparam logic [DW-1:0] V_ONE = 64'h1;
  localparam logic [DW-1:0] V_MAX = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          clka = 1'b0;
  logic          rsta, ena, wea, enb;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina, doutb;

  int vectors = 0;
  int miscompares = 0;

  blk_mem_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clka (clka),
    .rsta (rsta),
    .ena  (ena),
    .wea  (wea),
    .addra(addra),
    .dina (dina),
    .enb  (enb),
    .addrb(addrb),
    .doutb(doutb)
  );

  always #5 clka = ~clka;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ena = 1'b1; wea = 1'b1; addra = a; dina = d;
    tick();
    wea = 1'b0;
  endtask

  // Holds the address for LAT edges; output must not change before the last one.
  task automatic read(input string tag, input logic [AW-1:0] a,
                      input logic [DW-1:0] prev, input logic [DW-1:0] exp);
    enb = 1'b1; addrb = a;
    repeat (LAT - 1) tick();
    check({tag, "_early"}, doutb, prev);
    tick();
    check(tag, doutb, exp);
    enb = 1'b0;
  endtask

  initial begin
    rsta = 1'b1; ena = 1'b0; wea = 1'b0; enb = 1'b0;
    addra = '0; addrb = '0; dina = '0;
    tick(); tick();
    check("reset_state", doutb, '0);
    rsta = 1'b0;

    write(12'd0, V_A);
    write(12'd1, V_B);
    write(12'd5, 64'h0);
    write(12'd7, 64'h5);
    ena = 1'b0;

    read("rd_addr0", 12'd0, 64'h0, V_A);
    read("rd_addr1", 12'd1, V_A, V_B);
    read("rd_addr0_again", 12'd0, V_B, V_A);

    enb = 1'b0; addrb = 12'd1;
    tick(); tick();
    check("read_hold", doutb, V_A);

    ena = 1'b0; wea = 1'b1; addra = 12'd5; dina = 64'h1111;
    tick();
    ena = 1'b1; wea = 1'b0; dina = 64'h2222;
    tick();
    ena = 1'b0;
    read("write_gating", 12'd5, V_A, 64'h0);

    ena = 1'b1; wea = 1'b1; addra = 12'd7; dina = 64'h9;
    enb = 1'b1; addrb = 12'd7;
    tick();
    wea = 1'b0; ena = 1'b0;
    repeat (LAT - 1) tick();
    check("collision_old", doutb, 64'h5);
    enb = 1'b0;
    read("collision_new", 12'd7, (LAT == 2) ? 64'h9 : 64'h5, 64'h9);

    read("pre_reset", 12'd1, 64'h9, V_B);
    rsta = 1'b1; enb = 1'b1; addrb = 12'd0;
    ena = 1'b1; wea = 1'b1; addra = 12'd9; dina = 64'h77;
    tick();
    check("reset_mid_read", doutb, '0);
    rsta = 1'b0; enb = 1'b0; ena = 1'b0; wea = 1'b0;
    tick();
    check("reset_hold_zero", doutb, '0);
    read("mem_retained", 12'd0, 64'h0, V_A);
    read("write_during_reset", 12'd9, V_A, 64'h77);

    write(12'd4095, V_MAX);
    write(12'd0, V_ONE);
    ena = 1'b0;
    read("boundary_top", 12'd4095, 64'h77, V_MAX);
    read("boundary_zero", 12'd0, V_MAX, V_ONE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
